// File: rtl/gate_truth_table_sweeper.sv
// Sweeps every input vector onto a gate network, compares two responses and keeps score.
// Optional continuous re-sweep when GATE_SWEEP_LOOP_EN is defined.
module gate_truth_table_sweeper #(
    parameter int unsigned N_INPUTS      = 2,
    parameter int unsigned STEP_CYCLES   = 13_500_000,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                step,
    input  logic                auto_mode,
    input  logic                resp_a,
    input  logic                resp_b,
    output logic [N_INPUTS-1:0] stim,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [7:0]          mismatch_count,
    output logic                fail_valid,
    output logic [N_INPUTS-1:0] first_fail_vec
);

    localparam int unsigned CNT_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    HOLD_LAST   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
    localparam logic [N_INPUTS-1:0] LAST_VEC    = '1;

`ifdef GATE_SWEEP_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_HOLD, S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_start_q;
    logic                r_step_q;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [N_INPUTS-1:0] w_stim_next;
    logic [N_INPUTS-1:0] w_ffv_next;
    logic [7:0]          w_mm_next;
    logic                w_fv_next;
    logic                w_busy_next;
    logic                w_done_next;
    logic                w_pass_next;
    logic                w_start_edge;
    logic                w_step_edge;
    logic                w_leave_hold;

    assign w_start_edge = start & ~r_start_q;
    assign w_step_edge  = step & ~r_step_q;
    assign w_leave_hold = auto_mode ? (r_cnt >= HOLD_LAST) : w_step_edge;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start_edge) w_state_next = S_DRIVE;
            S_DRIVE:  w_state_next = S_SETTLE;
            S_SETTLE: if (r_cnt >= SETTLE_LAST) w_state_next = S_SAMPLE;
            S_SAMPLE: w_state_next = S_HOLD;
            S_HOLD:   if (w_leave_hold) w_state_next = (stim == LAST_VEC) ? S_DONE : S_DRIVE;
            S_DONE: begin
                // In loop mode the DONE cycle doubles as the drive cycle of vector 0
                if (LOOP_EN)           w_state_next = S_SETTLE;
                else if (w_start_edge) w_state_next = S_DRIVE;
            end
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Next values for the registered outputs and hold counter
    always_comb begin
        w_cnt_next  = (r_cnt == HOLD_LAST) ? r_cnt : r_cnt + CNT_W'(1);
        w_stim_next = stim;
        w_mm_next   = mismatch_count;
        w_fv_next   = fail_valid;
        w_ffv_next  = first_fail_vec;
        if ((r_state == S_IDLE || (r_state == S_DONE && !LOOP_EN)) && w_start_edge) begin
            w_stim_next = '0;
            w_mm_next   = 8'd0;
            w_fv_next   = 1'b0;
            w_ffv_next  = '0;
        end
        if (r_state == S_SAMPLE && resp_a != resp_b) begin
            if (mismatch_count != 8'hFF) w_mm_next = mismatch_count + 8'd1;
            if (!fail_valid) begin
                w_fv_next  = 1'b1;
                w_ffv_next = stim;
            end
        end
        if (r_state == S_HOLD && w_leave_hold) begin
            if (stim != LAST_VEC) w_stim_next = stim + N_INPUTS'(1);
            else if (LOOP_EN)     w_stim_next = '0;
        end
        if (w_state_next == S_DRIVE || (LOOP_EN && w_state_next == S_DONE)) w_cnt_next = '0;
        w_done_next = (w_state_next == S_DONE);
        w_busy_next = !(w_state_next == S_IDLE || (w_state_next == S_DONE && !LOOP_EN));
        w_pass_next = w_done_next && (w_mm_next == 8'd0);
    end

    // Edge detectors, hold counter and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_start_q      <= 1'b0;
            r_step_q       <= 1'b0;
            r_cnt          <= '0;
            stim           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_count <= 8'd0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            r_start_q      <= start;
            r_step_q       <= step;
            r_cnt          <= w_cnt_next;
            stim           <= w_stim_next;
            busy           <= w_busy_next;
            done           <= w_done_next;
            pass           <= w_pass_next;
            mismatch_count <= w_mm_next;
            fail_valid     <= w_fv_next;
            first_fail_vec <= w_ffv_next;
        end
    end

endmodule

// File: tb/tb_gate_truth_table_sweeper.sv
// Randomized self-checking bench for gate_truth_table_sweeper (N_INPUTS=2, STEP=8, SETTLE=2).
module tb_gate_truth_table_sweeper;

    localparam int unsigned STEP = 8;
    localparam int unsigned NVEC = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       step = 1'b0;
    logic       auto_mode = 1'b0;
    logic       resp_a;
    logic       resp_b;
    logic [1:0] stim;
    logic       busy, done, pass, fail_valid;
    logic [7:0] mismatch_count;
    logic [1:0] first_fail_vec;

    logic [3:0] tbl_b;
    logic       use_tbl = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;

    gate_truth_table_sweeper #(
        .N_INPUTS(2), .STEP_CYCLES(STEP), .SETTLE_CYCLES(2)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .step(step), .auto_mode(auto_mode),
        .resp_a(resp_a), .resp_b(resp_b), .stim(stim), .busy(busy), .done(done), .pass(pass),
        .mismatch_count(mismatch_count), .fail_valid(fail_valid), .first_fail_vec(first_fail_vec)
    );

    always #5 clock = ~clock;

    // Gate network: NAND vs De Morgan form, or an arbitrary faulty truth table on resp_b
    assign resp_a = ~(stim[1] & stim[0]);
    assign resp_b = use_tbl ? tbl_b[stim] : (~stim[1] | ~stim[0]);

    function automatic bit ref_a(input int v);
        return v != 3;
    endfunction

    function automatic bit ref_b(input int v);
        if (use_tbl) return tbl_b[v];
        return !((v / 2) == 1 && (v % 2) == 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected end-of-sweep score derived from the truth tables
    task automatic check_results(input int passes);
        int cnt = 0;
        int first = -1;
        for (int p = 0; p < passes; p++)
            for (int v = 0; v < NVEC; v++)
                if (ref_a(v) != ref_b(v)) begin
                    cnt++;
                    if (first < 0) first = v;
                end
        if (cnt > 255) cnt = 255;
        check_eq("mismatch_count", 32'(mismatch_count), 32'(cnt));
        check_eq("fail_valid", 32'(fail_valid), 32'(cnt != 0));
        check_eq("first_fail_vec", 32'(first_fail_vec), (first < 0) ? 32'd0 : 32'(first));
        check_eq("pass", 32'(pass), 32'(cnt == 0));
    endtask

    // Auto sweep with random noise on start (ignored while busy) and step (ignored in auto)
    task automatic auto_sweep(input bit tbl_en, input logic [3:0] tbl);
        use_tbl = tbl_en;
        tbl_b = tbl;
        auto_mode = 1'b1;
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        for (int k = 0; k < int'(STEP * NVEC); k++) begin
            check_eq("auto_stim", 32'(stim), 32'(k / STEP));
            check_eq("auto_busy", 32'(busy), 32'd1);
            start = (k < 28) ? 1'($urandom_range(0, 1)) : 1'b0;
            step = 1'($urandom_range(0, 1));
            tick();
        end
        step = 1'b0;
        check_eq("end_done", 32'(done), 32'd1);
        check_eq("end_busy", 32'(busy), 32'd0);
        check_eq("end_stim", 32'(stim), 32'd3);
        check_results(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl_b = 4'h0;
        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom_range(0, 1));
            step = 1'($urandom_range(0, 1));
            auto_mode = 1'($urandom_range(0, 1));
            tick();
        end
        check_eq("rst_outputs", {22'd0, stim, busy, done, pass, mismatch_count, fail_valid}, 32'd0);
        check_eq("rst_ffv", 32'(first_fail_vec), 32'd0);
        start = 1'b0;
        step = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_done", 32'(done), 32'd0);
        check_eq("idle_stim", 32'(stim), 32'd0);

`ifdef GATE_SWEEP_LOOP_EN
        use_tbl = 1'b1;
        tbl_b = 4'b1000;
        auto_mode = 1'b1;
        start = 1'b1;
        tick();
        for (int k = 0; k <= 3 * int'(STEP * NVEC); k++) begin
            check_eq("loop_busy", 32'(busy), 32'd1);
            check_eq("loop_done", 32'(done), 32'(k > 0 && k % 32 == 0));
            check_eq("loop_stim", 32'(stim), 32'((k % 32) / STEP));
            if (k > 0 && k % 32 == 0) check_eq("loop_pass", 32'(pass), 32'd0);
            if (k < 3 * int'(STEP * NVEC)) tick();
        end
        check_eq("loop_mm", 32'(mismatch_count), 32'd12);
        check_eq("loop_ffv", 32'(first_fail_vec), 32'd0);
        check_eq("loop_fv", 32'(fail_valid), 32'd1);
`else
        // Healthy network, then resp_b stuck at 1, then random faulty tables
        auto_sweep(1'b0, 4'h0);
        auto_sweep(1'b1, 4'hF);
        for (int t = 0; t < 4; t++) auto_sweep(1'b1, 4'($urandom_range(0, 15)));

        // Manual mode: stays put without steps, one advance per step edge
        use_tbl = 1'b0;
        auto_mode = 1'b0;
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check_eq("man_wait_stim", 32'(stim), 32'd0);
        check_eq("man_wait_busy", 32'(busy), 32'd1);
        for (int e = 1; e <= 4; e++) begin
            int hi = (e == 2) ? 5 : int'($urandom_range(1, 3));
            step = 1'b1;
            for (int i = 0; i < hi; i++) tick();
            step = 1'b0;
            for (int i = hi; i < 10; i++) tick();
            if (e < 4) check_eq("man_stim", 32'(stim), 32'(e));
        end
        check_eq("man_done", 32'(done), 32'd1);
        check_eq("man_busy", 32'(busy), 32'd0);
        check_eq("man_stim_end", 32'(stim), 32'd3);
        check_results(1);

        // Simultaneous start+step in DONE: start wins
        start = 1'b1;
        step = 1'b1;
        tick();
        check_eq("restart_busy", 32'(busy), 32'd1);
        check_eq("restart_stim", 32'(stim), 32'd0);
        check_eq("restart_done", 32'(done), 32'd0);
        start = 1'b0;
        step = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check_eq("restart_hold_stim", 32'(stim), 32'd0);

        // Reset mid-sweep aborts immediately
        auto_mode = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check_eq("pre_rst_stim", 32'(stim), 32'd2);
        reset = 1'b0;
        #1;
        check_eq("abort_outputs", {22'd0, stim, busy, done, pass, mismatch_count, fail_valid}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check_eq("abort_idle", 32'(busy), 32'd0);
        auto_sweep(1'b1, 4'b0110);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
